// File: rtl/rnn_host_seq_pkg.sv
`default_nettype none
// ============================================================================
// rnn_host_pkg : shared types and constants for the rnn host sequencer
// Revision     : 1.0
// ============================================================================
package rnn_host_pkg;

  localparam int P_EMB = 4;
  localparam int P_HID = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_LW, S_LR, S_LB, S_LD, S_LDB, S_READY, S_EMB, S_STEP, S_DENSE, S_RES
  } host_state_e;

  typedef enum logic [1:0] {WS_IDLE, WS_FETCH, WS_WRITE} wr_state_e;

  typedef enum logic [1:0] {PK_RC, PK_IDX, PK_VAL, PK_ZERO} pack_e;

  localparam logic [2:0] A_STEP  = 3'd0;
  localparam logic [2:0] A_EMB   = 3'd1;
  localparam logic [2:0] A_W     = 3'd2;
  localparam logic [2:0] A_R     = 3'd3;
  localparam logic [2:0] A_B     = 3'd4;
  localparam logic [2:0] A_D     = 3'd5;
  localparam logic [2:0] A_DB    = 3'd6;
  localparam logic [2:0] A_DENSE = 3'd7;

  // ROM base offset of each parameter segment; the ROM is packed W,R,B,D,dense bias,E.
  function automatic int seg_base(host_state_e s, int emb, int hid);
    case (s)
      S_LR:    return emb * hid;
      S_LB:    return emb * hid + hid * hid;
      S_LD:    return emb * hid + hid * hid + hid;
      S_LDB:   return emb * hid + hid * hid + 2 * hid;
      S_EMB:   return emb * hid + hid * hid + 2 * hid + 1;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rnn_host_seq_if.sv
`default_nettype none
// ============================================================================
// rnn_host_seq_if : register-write bus between host sequencer and accelerator
// Revision        : 1.0
// ============================================================================
interface rnn_host_seq_if;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_addr;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_read, m_write, m_addr, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_read, m_write, m_addr, m_writedata,
    output m_readdata, m_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/rnn_host_seq_word_writer.sv
`default_nettype none
// ============================================================================
// rnn_word_writer : streams COUNT ROM words to one bus register (FETCH/WRITE)
// Revision        : 1.0
// ============================================================================
module rnn_word_writer import rnn_host_pkg::*; #(
  parameter int HID    = P_HID,
  parameter int ROM_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROM_AW-1:0] base,
  input  logic [15:0]       count,
  input  logic [2:0]        bus_addr,
  input  pack_e             mode,
  input  logic              two_d,
  input  logic [15:0]       rom_data,
  input  logic              waitrequest,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              wr_strobe,
  output logic [2:0]        wr_addr,
  output logic [31:0]       wr_data,
  output logic              done
);

  wr_state_e         state_q, state_d;
  logic [ROM_AW-1:0] base_q, base_d;
  logic [15:0]       count_q, count_d;
  logic [2:0]        addr_q, addr_d;
  pack_e             mode_q, mode_d;
  logic              two_d_q, two_d_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WS_IDLE;
      base_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      mode_q  <= PK_ZERO;
      two_d_q <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      two_d_q <= two_d_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    two_d_d   = two_d_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    rom_addr  = '0;
    wr_strobe = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    done      = 1'b0;

    case (mode_q)
      PK_RC:   wr_data = {row_q, col_q, rom_data};
      PK_IDX:  wr_data = {idx_q, rom_data};
      PK_VAL:  wr_data = {16'h0000, rom_data};
      default: wr_data = '0;
    endcase

    case (state_q)
      WS_IDLE: begin
        wr_data = '0;
        if (start) begin
          base_d  = base;
          count_d = count;
          addr_d  = bus_addr;
          mode_d  = mode;
          two_d_d = two_d;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = WS_FETCH;
        end
      end
      WS_FETCH: begin
        wr_data  = '0;
        rom_addr = base_q + ROM_AW'(idx_q);
        state_d  = WS_WRITE;
      end
      WS_WRITE: begin
        // rom_addr stays put so the ROM keeps presenting the same word during a stall
        rom_addr  = base_q + ROM_AW'(idx_q);
        wr_strobe = 1'b1;
        wr_addr   = addr_q;
        if (!waitrequest) begin
          if (idx_q == count_q - 16'd1) begin
            done    = 1'b1;
            state_d = WS_IDLE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = WS_FETCH;
            if (two_d_q) begin
              if (col_q == 8'(HID - 1)) begin
                col_d = '0;
                row_d = row_q + 8'd1;
              end else begin
                col_d = col_q + 8'd1;
              end
            end
          end
        end
      end
      default: begin
        wr_data = '0;
        state_d = WS_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rnn_host_seq.sv
`default_nettype none
// ============================================================================
// rnn_host_seq : loads rnn parameters from ROM and runs per-sequence inference
// Revision     : 1.0
// ============================================================================
module rnn_host_seq import rnn_host_pkg::*; #(
  parameter int EMB    = P_EMB,
  parameter int HID    = P_HID,
  parameter int ROM_AW = 16,
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  output logic              load_done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [CHAR_W-1:0] char_id,
  input  logic              char_last,
  rnn_host_seq_if.master    bus,
  output logic              result_valid,
  output logic [31:0]       result_data
);

  host_state_e       state_q, state_d;
  logic              load_done_q, load_done_d;
  logic [CHAR_W-1:0] ch_q, ch_d;
  logic              last_q, last_d;
  logic [31:0]       result_q, result_d;
  logic              result_valid_q, result_valid_d;

  logic              wr_start, wr_2d, wr_done, wr_strobe, rd_strobe;
  logic [ROM_AW-1:0] wr_base;
  logic [15:0]       wr_count;
  logic [2:0]        wr_sel, wr_addr;
  pack_e             wr_mode;
  logic [31:0]       wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      load_done_q    <= 1'b0;
      ch_q           <= '0;
      last_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_done_q    <= load_done_d;
      ch_q           <= ch_d;
      last_q         <= last_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_done_d    = load_done_q;
    ch_d           = ch_q;
    last_d         = last_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    char_ready     = 1'b0;
    rd_strobe      = 1'b0;
    wr_start       = 1'b0;
    wr_base        = ROM_AW'(seg_base(state_q, EMB, HID));
    wr_count       = 16'd1;
    wr_sel         = A_STEP;
    wr_mode        = PK_ZERO;
    wr_2d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          load_done_d = 1'b0;
          state_d     = S_LW;
        end
      end
      S_LW: begin
        wr_start = 1'b1;
        wr_count = 16'(EMB * HID);
        wr_sel   = A_W;
        wr_mode  = PK_RC;
        wr_2d    = 1'b1;
        if (wr_done) state_d = S_LR;
      end
      S_LR: begin
        wr_start = 1'b1;
        wr_count = 16'(HID * HID);
        wr_sel   = A_R;
        wr_mode  = PK_RC;
        wr_2d    = 1'b1;
        if (wr_done) state_d = S_LB;
      end
      S_LB: begin
        wr_start = 1'b1;
        wr_count = 16'(HID);
        wr_sel   = A_B;
        wr_mode  = PK_IDX;
        if (wr_done) state_d = S_LD;
      end
      S_LD: begin
        wr_start = 1'b1;
        wr_count = 16'(HID);
        wr_sel   = A_D;
        wr_mode  = PK_IDX;
        if (wr_done) state_d = S_LDB;
      end
      S_LDB: begin
        wr_start = 1'b1;
        wr_sel   = A_DB;
        wr_mode  = PK_VAL;
        if (wr_done) begin
          load_done_d = 1'b1;
          state_d     = S_READY;
        end
      end
      S_READY: begin
        // a reload request wins over a character offered in the same cycle
        if (load_start) begin
          load_done_d = 1'b0;
          state_d     = S_LW;
        end else begin
          char_ready = 1'b1;
          if (char_valid) begin
            ch_d    = char_id;
            last_d  = char_last;
            state_d = S_EMB;
          end
        end
      end
      S_EMB: begin
        wr_start = 1'b1;
        wr_base  = ROM_AW'(seg_base(S_EMB, EMB, HID) + int'(ch_q) * EMB);
        wr_count = 16'(EMB);
        wr_sel   = A_EMB;
        wr_mode  = PK_IDX;
        if (wr_done) state_d = S_STEP;
      end
      S_STEP: begin
        wr_start = 1'b1;
        wr_sel   = A_STEP;
        if (wr_done) state_d = last_q ? S_DENSE : S_READY;
      end
      S_DENSE: begin
        wr_start = 1'b1;
        wr_sel   = A_DENSE;
        if (wr_done) state_d = S_RES;
      end
      S_RES: begin
        rd_strobe = 1'b1;
        if (!bus.m_waitrequest) begin
          result_d       = bus.m_readdata;
          result_valid_d = 1'b1;
          state_d        = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  rnn_word_writer #(
    .HID    (HID),
    .ROM_AW (ROM_AW)
  ) u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (wr_start),
    .base        (wr_base),
    .count       (wr_count),
    .bus_addr    (wr_sel),
    .mode        (wr_mode),
    .two_d       (wr_2d),
    .rom_data    (rom_data),
    .waitrequest (bus.m_waitrequest),
    .rom_addr    (rom_addr),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .done        (wr_done)
  );

  assign bus.m_read      = rd_strobe;
  assign bus.m_write     = wr_strobe;
  assign bus.m_addr      = rd_strobe ? A_DENSE : wr_addr;
  assign bus.m_writedata = wr_data;

  assign load_done    = load_done_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_rnn_host_seq.sv
`default_nettype none
// ============================================================================
// tb_rnn_host_seq : randomized bench for rnn_host_seq with a transaction model
// Revision        : 1.0
// ============================================================================
module tb_rnn_host_seq;
  import rnn_host_pkg::*;

  localparam int EMB = 4, HID = 32, ROM_AW = 16, CHAR_W = 8;

  logic              clk, rst_n, load_start, load_done;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              char_valid, char_ready, char_last, result_valid;
  logic [CHAR_W-1:0] char_id;
  logic [31:0]       result_data;

  rnn_host_seq_if bus ();

  rnn_host_seq #(.EMB(EMB), .HID(HID), .ROM_AW(ROM_AW), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_done(load_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .char_valid(char_valid),
    .char_ready(char_ready), .char_id(char_id), .char_last(char_last), .bus(bus),
    .result_valid(result_valid), .result_data(result_data)
  );

  typedef logic [35:0] xact_t;   // {is_read, addr, data}
  xact_t obs[$], exp_q[$];
  logic [15:0] rom_mem [0:65535];

  int total = 0, bad = 0;
  int stall_mode = 0, rd_stall = -1, stall_left = 0, wr_cnt = 0;
  int overlap = 0, unstable = 0, strobe_in_reset = 0, ready_viol = 0, res_cnt = 0;
  logic [31:0] rd_value = 32'h0;
  logic        wait_r = 1'b0, in_xfer = 1'b0;
  logic [36:0] held = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Slave: decides stalls per transaction and records every accepted transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (bus.m_write || bus.m_read) strobe_in_reset++;
      wait_r = 1'b0;
      in_xfer = 1'b0;
    end else begin
      if (bus.m_write && bus.m_read) overlap++;
      if (wait_r && ({bus.m_read, bus.m_write, bus.m_addr, bus.m_writedata} !== held)) unstable++;
      if (bus.m_write || bus.m_read) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          held = {bus.m_read, bus.m_write, bus.m_addr, bus.m_writedata};
          if (bus.m_write) wr_cnt++;
          if (bus.m_read && rd_stall >= 0) stall_left = rd_stall;
          else if (stall_mode == 1) stall_left = (bus.m_write && (wr_cnt % 10 == 0)) ? 3 : 0;
          else if (stall_mode == 2) stall_left = $urandom_range(0, 2);
          else stall_left = 0;
        end
        bus.m_readdata = rd_value;
        if (stall_left > 0) begin
          wait_r = 1'b1;
          stall_left--;
        end else begin
          wait_r = 1'b0;
          in_xfer = 1'b0;
          obs.push_back({bus.m_read, bus.m_addr, bus.m_read ? 32'h0 : bus.m_writedata});
        end
      end else begin
        wait_r = 1'b0;
        in_xfer = 1'b0;
      end
    end
    bus.m_waitrequest = wait_r;
  end

  always @(negedge clk) begin
    if (rst_n && result_valid) res_cnt++;
    if (rst_n && char_ready && !load_done) ready_viol++;
  end

  function automatic xact_t wr(input logic [2:0] a, input logic [31:0] d);
    return {1'b0, a, d};
  endfunction

  task automatic model_load();
    for (int r = 0; r < EMB; r++)
      for (int c = 0; c < HID; c++)
        exp_q.push_back(wr(3'd2, {8'(r), 8'(c), rom_mem[r * HID + c]}));
    for (int r = 0; r < HID; r++)
      for (int c = 0; c < HID; c++)
        exp_q.push_back(wr(3'd3, {8'(r), 8'(c), rom_mem[128 + r * HID + c]}));
    for (int i = 0; i < HID; i++) exp_q.push_back(wr(3'd4, {16'(i), rom_mem[1152 + i]}));
    for (int i = 0; i < HID; i++) exp_q.push_back(wr(3'd5, {16'(i), rom_mem[1184 + i]}));
    exp_q.push_back(wr(3'd6, {16'h0, rom_mem[1216]}));
  endtask

  task automatic model_char(input int ch, input bit last);
    for (int i = 0; i < EMB; i++) exp_q.push_back(wr(3'd1, {16'(i), rom_mem[1217 + ch * EMB + i]}));
    exp_q.push_back(wr(3'd0, 32'h0));
    if (last) begin
      exp_q.push_back(wr(3'd7, 32'h0));
      exp_q.push_back({1'b1, 3'd7, 32'h0});
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), obs[i], exp_q[i]);
  endtask

  task automatic clear_queues();
    obs.delete();
    exp_q.delete();
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_load();
    int n = 0;
    while (!load_done && n < 30000) begin @(negedge clk); n++; end
    if (!load_done) check("load_timeout", 0, 1);
  endtask

  task automatic send_char(input int ch, input bit last);
    int n = 0;
    char_valid = 1'b1;
    char_id = CHAR_W'(ch);
    char_last = last;
    while (!char_ready && n < 20000) begin @(negedge clk); n++; end
    if (!char_ready) check("char_accept_timeout", 0, 1);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_result(input int res0);
    int n = 0;
    while (res_cnt == res0 && n < 5000) begin @(negedge clk); n++; end
    if (res_cnt == res0) check("result_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int res0, len, cx;
    int chars[4];
    rst_n = 1'b0; load_start = 1'b0; char_valid = 1'b0; char_id = '0; char_last = 1'b0;
    bus.m_readdata = 32'h0; bus.m_waitrequest = 1'b0;
    for (int k = 0; k < 65536; k++) rom_mem[k] = 16'(k);
    repeat (3) @(negedge clk);
    check("rst_load_done", load_done, 0);
    check("rst_char_ready", char_ready, 0);
    check("rst_m_write", bus.m_write, 0);
    check("rst_m_read", bus.m_read, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain load with ROM word k = k
    clear_queues(); model_load();
    pulse_load(); wait_load();
    check("load_count", obs.size(), 1217);
    check("first_w", obs[0], {1'b0, 3'd2, 32'h00000000});
    check("w33", obs[32], {1'b0, 3'd2, 32'h01000020});
    check("last_w", obs[127], {1'b0, 3'd2, 32'h031F007F});
    check("ldb", obs[1216], {1'b0, 3'd6, 32'h000004C0});
    check("load_done_set", load_done, 1);
    compare_all("load_plain");

    // Reload with random ROM and periodic stalls
    for (int k = 0; k < 2300; k++) rom_mem[k] = 16'($urandom);
    stall_mode = 1; wr_cnt = 0;
    clear_queues(); model_load();
    pulse_load();
    check("load_done_cleared", load_done, 0);
    wait_load();
    compare_all("load_stall");

    // Char 0 then char 1 (last), long stall on the result read
    stall_mode = 0; rd_stall = 50; rd_value = 32'hFFFF_FF9C;
    clear_queues(); model_char(0, 0); model_char(1, 1);
    res0 = res_cnt;
    send_char(0, 0); send_char(1, 1);
    wait_result(res0);
    check("seq01_pulses", res_cnt - res0, 1);
    check("seq01_result", result_data, 32'hFFFF_FF9C);
    compare_all("seq01");

    // Random sequences with random stalls
    stall_mode = 2; rd_stall = -1;
    for (int s = 0; s < 3; s++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) chars[i] = $urandom_range(0, 255);
      rd_value = $urandom;
      clear_queues();
      for (int i = 0; i < len; i++) model_char(chars[i], i == len - 1);
      res0 = res_cnt;
      for (int i = 0; i < len; i++) send_char(chars[i], i == len - 1);
      wait_result(res0);
      check($sformatf("rseq%0d_pulses", s), res_cnt - res0, 1);
      check($sformatf("rseq%0d_result", s), result_data, rd_value);
      compare_all($sformatf("rseq%0d", s));
    end

    // Reset in the middle of the R segment, then reload with a character pending
    obs.delete();
    pulse_load();
    begin
      int n = 0;
      while (obs.size() < 628 && n < 30000) begin @(negedge clk); n++; end
      if (obs.size() < 628) check("mid_lr_timeout", 0, 1);
    end
    #2 rst_n = 1'b0;
    #1 check("rst_mid_load_done", load_done, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    cx = $urandom_range(0, 255);
    rd_value = $urandom;
    clear_queues(); model_load(); model_char(cx, 1);
    char_valid = 1'b1; char_id = CHAR_W'(cx); char_last = 1'b1;
    res0 = res_cnt;
    pulse_load(); wait_load();
    check("char_ready_first_ready", char_ready, 1);
    @(negedge clk);
    char_valid = 1'b0;
    check("char_taken", char_ready, 0);
    wait_result(res0);
    check("reload_result", result_data, rd_value);
    compare_all("reload");

    check("rd_wr_overlap", overlap, 0);
    check("strobe_stable", unstable, 0);
    check("strobe_in_reset", strobe_in_reset, 0);
    check("ready_before_load", ready_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rnn_host_seq.md
Name: rnn_host_seq

Overview:
- Bus initiator that drives the rnn accelerator's 32-bit register-write slave port (read, write, addr[2:0], data_in, data_out).
- Streams the parameter set from a flat 16-bit parameter ROM into the accelerator: input weights, recurrent matrix, bias, dense vector and dense bias.
- Then runs one inference per character sequence: for each character it loads the embedding and issues a step; at sequence end it triggers the dense layer and reads back the result.
- Replaces the hand-sequenced bus traffic with synthesizable control in the SoC.

Parameters:
EMB, 4, embedding length (rows of W)
HID, 32, hidden size (cols of W, rows/cols of R, length of B and D)
ROM_AW, 16, parameter ROM address width
CHAR_W, 8, character id width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse; (re)load all parameters
load_done  out  1  high once parameters are loaded; cleared by load_start or reset
rom_addr  out  ROM_AW  parameter ROM address
rom_data  in  16  ROM data, valid exactly 1 cycle after rom_addr
char_valid  in  1  character stream valid
char_ready  out  1  character accepted when char_valid && char_ready
char_id  in  CHAR_W  character index
char_last  in  1  last character of the sequence
m_read  out  1  bus read strobe
m_write  out  1  bus write strobe
m_addr  out  3  bus register address
m_writedata  out  32  bus write data
m_readdata  in  32  bus read data
m_waitrequest  in  1  slave stall; a strobe is held unchanged while this is high
result_valid  out  1  one-cycle pulse carrying the result
result_data  out  32  result captured from m_readdata

Behaviour:
- Reset (async, any state): go to IDLE. All outputs 0, counters 0, load_done=0.
- ROM map (word addresses):
  - W[r][c] at r*HID+c (0..127)
  - R[r][c] at 128+r*HID+c (128..1151)
  - B[i] at 1152+i
  - D[i] at 1184+i
  - dense bias at 1216
  - E[ch][i] at 1217+ch*EMB+i
- Word transfer takes two phases:
  - FETCH: drive rom_addr.
  - WRITE: m_write=1 with the packed word; held until the cycle m_waitrequest=0, then advance.
  - Minimum 2 cycles per word.
- Write data packing:
  - addr 2 (W) and addr 3 (R): {row[7:0], col[7:0], value}
  - addr 4 (B), addr 5 (D), addr 1 (E): {idx[15:0], value}
  - addr 6 (dense bias): {16'b0, value}
  - addr 0 (step) and addr 7 (dense): writedata 0
- States:
  - IDLE: load_start moves to LW.
  - LW: 128 words to addr 2; col increments first; row carries when col wraps from HID-1.
  - LR: 1024 words to addr 3.
  - LB: 32 words to addr 4.
  - LD: 32 words to addr 5.
  - LDB: 1 word to addr 6.
  - READY: set load_done=1.
- In READY: char_ready=1. On handshake, latch char_id and char_last, then go to EMB.
- EMB: 4 words to addr 1 at idx 0..3.
- STEP: single write to addr 0, held through waitrequest (the slave stalls until the step completes).
- After STEP:
  - If char_last: go to DENSE.
  - Otherwise: return to READY.
- DENSE: write to addr 7, held through waitrequest.
- RES: m_read=1 with m_addr=7, held until m_waitrequest=0. In that cycle, capture m_readdata into result_data and pulse result_valid next cycle. The slave clears its hidden state on this read. Then return to READY.
- Strobe rules:
  - m_read and m_write are never both high.
  - m_addr and m_writedata are stable while a strobe is held.
- char_ready=0 outside READY. char_valid outside READY is not consumed.
- load_start in READY (between sequences) restarts at LW and clears load_done.
- load_start is ignored in every other non-IDLE state.
- result_data holds its value until the next capture.

Decomposition:
- Package rnn_host_pkg holds:
  - state enum
  - bus address constants (A_STEP=0, A_EMB=1, A_W=2, A_R=3, A_B=4, A_D=5, A_DB=6, A_DENSE=7)
  - ROM base offsets
- Sub-module rnn_word_writer is natural: the FETCH/WRITE two-phase engine with a waitrequest hold. It takes base, count, bus address, packing mode and a 2-D/1-D flag, and returns done.

Test Plan:
- Load with waitrequest=0, ROM word k = k[15:0] -> exactly 1217 writes. First write is addr 2, data 0x00000000; write #33 is 0x01000020; the last W write is 0x031F007F; the LDB write is 0x000004C0; load_done rises.
- Load with waitrequest high 3 cycles on every 10th write -> same 1217 words in the same order, no duplicates, strobe and data stable while stalled.
- Sequence char 0 then char 1 (last) -> EMB writes use ROM 1217..1220, then 1221..1224. Order: E×4, step, E×4, step, write addr 7, read addr 7.
- Hold waitrequest 50 cycles on the final read, m_readdata=0xFFFF_FF9C -> result_data=0xFFFFFF9C with a single result_valid pulse.
- Reset asserted mid-LR at word 500, then load_start -> load restarts at W[0][0]; no write occurs during reset.
- char_valid high during loading -> char_ready=0; the character is accepted on the first READY cycle after load_done.
